// File: rtl/bch_pkg.sv
// Shared types and GF(2^m) arithmetic for the BCH Berlekamp-Massey engine.
// Field functions work on a fixed maximum width; the active width is passed as m.
package bch_pkg;

    typedef enum logic [2:0] {IDLE, DISC, UPD, NORM, DONE} bm_state_t;

    localparam int GF_MAX_M = 16;

    typedef logic [GF_MAX_M-1:0] gf_elem_t;
    typedef logic [GF_MAX_M:0]   gf_poly_t;

    localparam logic [4:0] PRIM_POLY_M4 = 5'h13;
    localparam logic [5:0] PRIM_POLY_M5 = 6'h25;
    localparam logic [6:0] PRIM_POLY_M6 = 7'h43;
    localparam logic [7:0] PRIM_POLY_M7 = 8'h89;
    localparam logic [8:0] PRIM_POLY_M8 = 9'h11D;

    // Shift-and-add multiply with reduction by poly after every shift.
    function automatic gf_elem_t gf_mul_f(input gf_elem_t a, input gf_elem_t b,
                                          input gf_poly_t poly, input int m);
        gf_elem_t acc;
        gf_poly_t sh;
        acc = '0;
        sh  = {1'b0, a};
        for (int i = 0; i < GF_MAX_M; i++) begin
            if (i < m) begin
                if (b[i]) acc ^= sh[GF_MAX_M-1:0];
                sh = sh << 1;
                if (sh[5'(m)]) sh ^= poly;
            end
        end
        return acc;
    endfunction

    // a^(2^m - 2) by repeated squaring; the inverse of zero comes out as zero.
    function automatic gf_elem_t gf_inv_f(input gf_elem_t a, input gf_poly_t poly, input int m);
        gf_elem_t sq;
        gf_elem_t res;
        sq  = a;
        res = gf_elem_t'(1);
        for (int i = 1; i < GF_MAX_M; i++) begin
            if (i < m) begin
                sq  = gf_mul_f(sq, sq, poly, m);
                res = gf_mul_f(res, sq, poly, m);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gf_mult_param.sv
// Combinational M-bit GF(2^M) multiplier, one per coefficient lane.
module gf_mult_param
    import bch_pkg::*;
#(
    parameter int         M         = 5,
    parameter logic [M:0] PRIM_POLY = 6'h25
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    assign p = M'(gf_mul_f(GF_MAX_M'(a), GF_MAX_M'(b), (GF_MAX_M+1)'(PRIM_POLY), M));

endmodule

// File: rtl/bch_bm_seq.sv
// Sequential inversionless Berlekamp-Massey solver for binary BCH over GF(2^M).
// Define BCH_BM_NORM_EN to add a final NORM step that scales the locator to Lambda0 = 1.
module bch_bm_seq
    import bch_pkg::*;
#(
    parameter int         M         = 5,
    parameter int         T         = 2,
    parameter logic [M:0] PRIM_POLY = 6'h25,
    parameter int         LW        = $clog2(2*T+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*T*M-1:0]     syn_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(T+1)*M-1:0]   lambda_o,
    output logic [LW-1:0]        deg_o,
    output logic                 fail_o
);

    bm_state_t      state_reg, state_next;
    logic [M-1:0]   syn_reg [1:2*T];
    logic [M-1:0]   lam_reg [0:T];
    logic [M-1:0]   b_reg   [0:T];
    logic [M-1:0]   gamma_reg, delta_reg;
    logic [LW-1:0]  l_reg, r_reg;

    logic [M-1:0]   disc_prod  [0:T];
    logic [M-1:0]   scale_prod [0:T];
    logic [M-1:0]   corr_prod  [0:T];
    logic [M-1:0]   x_lam      [0:T];
    logic [M-1:0]   x2_b       [0:T];
    logic [M-1:0]   scale_op, delta_sum;
    logic           accept, swap;

`ifdef BCH_BM_NORM_EN
    logic           lam0_zero_reg;
    logic [M-1:0]   inv_lam0;
    assign inv_lam0 = M'(gf_inv_f(GF_MAX_M'(lam_reg[0]), (GF_MAX_M+1)'(PRIM_POLY), M));
    // The gamma*Lambda lanes are reused for the final scaling by inv(Lambda0).
    assign scale_op = (state_reg == NORM) ? inv_lam0 : gamma_reg;
    assign fail_o   = (l_reg > LW'(T)) || lam0_zero_reg;
`else
    assign scale_op = gamma_reg;
    assign fail_o   = (l_reg > LW'(T));
`endif

    assign accept = in_valid && in_ready;
    assign swap   = (delta_reg != '0) && (l_reg <= r_reg);
    assign deg_o  = l_reg;

    genvar gi;
    generate
        for (gi = 0; gi <= T; gi++) begin : g_lane
            logic [M-1:0] syn_sel;
            logic [M-1:0] x_b;

            // Syndrome S(2r+1-i); indices outside 1..2T contribute nothing.
            always_comb begin
                syn_sel = '0;
                for (int j = 1; j <= 2*T; j++) begin
                    if (2*int'(r_reg) + 1 - gi == j) syn_sel = syn_reg[j];
                end
            end

            if (gi == 0) begin : g_low
                assign x_b       = '0;
                assign x_lam[gi] = '0;
                assign x2_b[gi]  = '0;
            end else if (gi == 1) begin : g_one
                assign x_b       = b_reg[gi-1];
                assign x_lam[gi] = lam_reg[gi-1];
                assign x2_b[gi]  = '0;
            end else begin : g_high
                assign x_b       = b_reg[gi-1];
                assign x_lam[gi] = lam_reg[gi-1];
                assign x2_b[gi]  = b_reg[gi-2];
            end

            gf_mult_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_disc (
                .a(lam_reg[gi]), .b(syn_sel), .p(disc_prod[gi]));
            gf_mult_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_scale (
                .a(scale_op), .b(lam_reg[gi]), .p(scale_prod[gi]));
            gf_mult_param #(.M(M), .PRIM_POLY(PRIM_POLY)) u_corr (
                .a(delta_reg), .b(x_b), .p(corr_prod[gi]));

            assign lambda_o[gi*M +: M] = lam_reg[gi];
        end
    endgenerate

    always_comb begin
        delta_sum = '0;
        for (int i = 0; i <= T; i++) delta_sum ^= disc_prod[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DISC;
            end
            DISC: state_next = UPD;
            UPD: begin
                if (r_reg < LW'(T-1)) state_next = DISC;
`ifdef BCH_BM_NORM_EN
                else                  state_next = NORM;
`else
                else                  state_next = DONE;
`endif
            end
            NORM: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= T; i++) begin
                lam_reg[i] <= '0;
                b_reg[i]   <= '0;
            end
            lam_reg[0] <= M'(1);
            b_reg[0]   <= M'(1);
            for (int j = 1; j <= 2*T; j++) syn_reg[j] <= '0;
            gamma_reg <= M'(1);
            delta_reg <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
`ifdef BCH_BM_NORM_EN
            lam0_zero_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i <= T; i++) begin
                            lam_reg[i] <= '0;
                            b_reg[i]   <= '0;
                        end
                        lam_reg[0] <= M'(1);
                        b_reg[0]   <= M'(1);
                        for (int j = 1; j <= 2*T; j++) syn_reg[j] <= syn_i[(j-1)*M +: M];
                        gamma_reg <= M'(1);
                        l_reg     <= '0;
                        r_reg     <= '0;
`ifdef BCH_BM_NORM_EN
                        lam0_zero_reg <= 1'b0;
`endif
                    end
                end
                DISC: delta_reg <= delta_sum;
                UPD: begin
                    for (int i = 0; i <= T; i++) begin
                        lam_reg[i] <= scale_prod[i] ^ corr_prod[i];
                        b_reg[i]   <= swap ? x_lam[i] : x2_b[i];
                    end
                    if (swap) begin
                        gamma_reg <= delta_reg;
                        l_reg     <= LW'(2*int'(r_reg) + 1 - int'(l_reg));
                    end
                    r_reg <= r_reg + LW'(1);
                end
`ifdef BCH_BM_NORM_EN
                NORM: begin
                    if (lam_reg[0] != '0) begin
                        for (int i = 0; i <= T; i++) lam_reg[i] <= scale_prod[i];
                    end
                    lam0_zero_reg <= (lam_reg[0] == '0);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
